// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the multi-channel pulse synchroniser:
// edge-mode selectors and the per-channel FSM state encoding.
package pulse_sync_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_sync_chan.sv
// One channel: synchroniser chain, edge detector, pulse/gap pacing FSM
// and a saturating queue of events that arrived while the channel was busy.
module pulse_sync_chan
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int PULSE_W     = 1,
  parameter int GAP_W       = 1,
  parameter int PEND_W      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic clr_ovf,
  output logic pulse,
  output logic busy,
  output logic overflow
);

  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;
  localparam logic NO_GAP = (GAP_W == 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [PEND_W-1:0]      pend_q;
  logic [PEND_W-1:0]      pend_next;

  logic sync_last;
  logic evt;
  logic pend_nz;
  logic pend_full;
  logic cnt_zero;
  logic can_start;
  logic start;
  logic pend_inc;
  logic pend_dec;
  logic drop;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign evt = (EDGE_MODE == EDGE_RISE) ? (sync_last & ~hist_q) :
               (EDGE_MODE == EDGE_FALL) ? (~sync_last & hist_q) :
                                          (sync_last ^ hist_q);

  assign pend_nz   = (pend_q != '0);
  assign pend_full = &pend_q;
  assign cnt_zero  = (cnt_q == '0);

  // A new pulse may begin from IDLE, at the end of a gap, or straight
  // after a pulse when no gap is configured.
  assign can_start = (state_q == ST_IDLE) ||
                     ((state_q == ST_GAP) && cnt_zero) ||
                     ((state_q == ST_PULSE) && cnt_zero && NO_GAP);
  assign start     = can_start && (evt || pend_nz);

  // Queued events are served first; a coincident new event then takes its slot.
  assign pend_dec = start && pend_nz;
  assign pend_inc = evt && (pend_dec || !start);
  assign drop     = pend_inc && !pend_dec && pend_full;

  always_comb begin
    pend_next = pend_q;
    if (pend_inc && !pend_dec && !pend_full) begin
      pend_next = pend_q + PEND_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_next = pend_q - PEND_W'(1);
    end
  end

  assign busy = (state_q != ST_IDLE) || pend_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      pulse    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q   <= sync_last;
      pend_q   <= pend_next;
      overflow <= drop || (overflow && !clr_ovf);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_PULSE;
            pulse   <= 1'b1;
            cnt_q   <= PULSE_LOAD;
          end
        end
        ST_PULSE: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (start) begin
            pulse <= 1'b1;
            cnt_q <= PULSE_LOAD;
          end else if (NO_GAP) begin
            state_q <= ST_IDLE;
            pulse   <= 1'b0;
          end else begin
            state_q <= ST_GAP;
            pulse   <= 1'b0;
            cnt_q   <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (start) begin
            state_q <= ST_PULSE;
            pulse   <= 1'b1;
            cnt_q   <= PULSE_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pulse   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_sync_multi.sv
// Multi-channel CDC pulse synchroniser: CHANNELS independent copies of
// pulse_sync_chan sharing one clock and reset.
module pulse_sync_multi
  import pulse_sync_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int PULSE_W     = 1,
  parameter int GAP_W       = 1,
  parameter int PEND_W      = 3
) (
  input  logic                o_clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] i_pulse,
  input  logic [CHANNELS-1:0] i_clr_ovf,
  output logic [CHANNELS-1:0] o_pulse,
  output logic [CHANNELS-1:0] o_busy,
  output logic [CHANNELS-1:0] o_overflow
);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH ||
      PULSE_W < 1 || GAP_W < 0 || PEND_W < 1) begin : g_bad_params
    $error("pulse_sync_multi: illegal parameter combination");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pulse_sync_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE),
      .PULSE_W    (PULSE_W),
      .GAP_W      (GAP_W),
      .PEND_W     (PEND_W)
    ) u_chan (
      .clk     (o_clk),
      .rst_n   (rst),
      .async_in(i_pulse[g]),
      .clr_ovf (i_clr_ovf[g]),
      .pulse   (o_pulse[g]),
      .busy    (o_busy[g]),
      .overflow(o_overflow[g])
    );
  end

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Self-checking bench for pulse_sync_multi: directed vector table, hand-derived
// multi-cycle sequences on three parameter sets, and randomized traffic vs a queue model.
module tb_pulse_sync_multi;

  localparam int NCH     = 4;
  localparam int M_P     = 1;
  localparam int M_G     = 1;
  localparam int M_DEPTH = 7;

  logic clk = 1'b0;
  logic rst;

  logic [NCH-1:0] a_in, a_clr, a_pulse, a_busy, a_ovf;
  logic [NCH-1:0] b_in, b_clr, b_pulse, b_busy, b_ovf;
  logic [NCH-1:0] c_in, c_clr, c_pulse, c_busy, c_ovf;

  pulse_sync_multi #(
    .CHANNELS(NCH), .SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_W(1), .GAP_W(1), .PEND_W(3)
  ) dut (
    .o_clk(clk), .rst(rst), .i_pulse(a_in), .i_clr_ovf(a_clr),
    .o_pulse(a_pulse), .o_busy(a_busy), .o_overflow(a_ovf)
  );

  pulse_sync_multi #(
    .CHANNELS(NCH), .SYNC_STAGES(2), .EDGE_MODE(2), .PULSE_W(2), .GAP_W(3), .PEND_W(3)
  ) dut_both (
    .o_clk(clk), .rst(rst), .i_pulse(b_in), .i_clr_ovf(b_clr),
    .o_pulse(b_pulse), .o_busy(b_busy), .o_overflow(b_ovf)
  );

  pulse_sync_multi #(
    .CHANNELS(NCH), .SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_W(4), .GAP_W(4), .PEND_W(2)
  ) dut_ovf (
    .o_clk(clk), .rst(rst), .i_pulse(c_in), .i_clr_ovf(c_clr),
    .o_pulse(c_pulse), .o_busy(c_busy), .o_overflow(c_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] pulse_in;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] exp_pulse;
    logic [NCH-1:0] exp_busy;
    logic [NCH-1:0] exp_ovf;
  } vec_t;

  vec_t vecs [18];

  int check_count = 0;
  int pass_count  = 0;

  logic [NCH-1:0] ep, eb, eo;

  // Reference model: per-channel queue of waiting events and the earliest
  // cycle at which the next pulse may start.
  logic samp [NCH][0:511];
  int   m_q    [NCH];
  int   m_next [NCH];
  int   m_last [NCH];
  logic m_ovf  [NCH];
  int   hold   [NCH];
  logic [NCH-1:0] lvl;

  task automatic checkOutput(input string name, input logic [NCH-1:0] actual,
                             input logic [NCH-1:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end else begin
      pass_count++;
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] p, input logic [NCH-1:0] c);
    a_in  = p;
    a_clr = c;
  endtask

  task automatic modelStep(input int e, input logic [NCH-1:0] pin, input logic [NCH-1:0] pclr);
    for (int c = 0; c < NCH; c++) begin
      logic nw, od, ev, set;
      samp[c][e] = pin[c];
      nw = (e - 2 >= 1) ? samp[c][e-2] : 1'b0;
      od = (e - 3 >= 1) ? samp[c][e-3] : 1'b0;
      ev = nw & ~od;
      set = 1'b0;
      if (ev) m_q[c]++;
      if (e >= m_next[c] && m_q[c] > 0) begin
        m_q[c]--;
        m_last[c] = e;
        m_next[c] = e + M_P + M_G;
      end
      if (m_q[c] > M_DEPTH) begin
        m_q[c] = M_DEPTH;
        set = 1'b1;
      end
      m_ovf[c] = set | (m_ovf[c] & ~pclr[c]);
      ep[c] = (e >= m_last[c]) && (e < m_last[c] + M_P);
      eb[c] = (m_q[c] > 0) || (m_next[c] > e);
      eo[c] = m_ovf[c];
    end
  endtask

  initial begin
    //           in       clr      pulse    busy     ovf
    vecs[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    vecs[3]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    vecs[4]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0011, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    vecs[8]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[9]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[13] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[14] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[15] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    rst = 1'b0;
    a_in = 4'b0010; a_clr = '0;
    b_in = '0; b_clr = '0;
    c_in = '0; c_clr = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pulse", a_pulse | b_pulse | c_pulse, '0);
    checkOutput("rst_busy", a_busy | b_busy | c_busy, '0);
    checkOutput("rst_ovf", a_ovf | b_ovf | c_ovf, '0);

    // Channel 1 is already high at release and must count as one rising edge.
    rst = 1'b1;
    for (int k = 0; k < 18; k++) begin
      applyStimulus(vecs[k].pulse_in, vecs[k].clr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_pulse", k), a_pulse, vecs[k].exp_pulse);
      checkOutput($sformatf("vec%0d_busy", k), a_busy, vecs[k].exp_busy);
      checkOutput($sformatf("vec%0d_ovf", k), a_ovf, vecs[k].exp_ovf);
    end

    // Both-edge pacing: events at edges 3,5,7,9 become pulses starting 3,8,13,18.
    for (int e = 1; e <= 26; e++) begin
      b_in = '0;
      b_in[2] = (e <= 6) && (((e - 1) / 2) % 2 == 0);
      @(negedge clk);
      ep = '0; eb = '0;
      ep[2] = (e >= 3) && (e <= 22) && ((e - 3) % 5 < 2);
      eb[2] = (e >= 3) && (e <= 22);
      checkOutput($sformatf("both_e%0d_pulse", e), b_pulse, ep);
      checkOutput($sformatf("both_e%0d_busy", e), b_busy, eb);
    end

    // Overflow: ten rising edges 4 cycles apart against an 8-cycle service time
    // and a 3-deep queue; drops occur at edges 31 and 39, clear requested at 35 and 39.
    for (int e = 1; e <= 70; e++) begin
      c_in = '0; c_clr = '0;
      c_in[3]  = (e <= 38) && ((e - 1) % 4 < 2);
      c_clr[3] = (e == 35) || (e == 39);
      @(negedge clk);
      ep = '0; eb = '0; eo = '0;
      ep[3] = (e >= 3) && (e <= 62) && ((e - 3) % 8 < 4);
      eb[3] = (e >= 3) && (e <= 66);
      eo[3] = ((e >= 31) && (e <= 34)) || (e >= 39);
      checkOutput($sformatf("ovf_e%0d_pulse", e), c_pulse, ep);
      checkOutput($sformatf("ovf_e%0d_busy", e), c_busy, eb);
      checkOutput($sformatf("ovf_e%0d_flag", e), c_ovf, eo);
    end
    c_clr = 4'b1000;
    @(negedge clk);
    checkOutput("ovf_clear", c_ovf, '0);
    c_clr = '0;
    @(negedge clk);
    checkOutput("ovf_clear_hold", c_ovf, '0);

    // Reset mid-operation: channel 3 is in PULSE with a full queue at edge 29.
    for (int e = 1; e <= 29; e++) begin
      c_in = '0;
      c_in[3] = (e <= 38) && ((e - 1) % 4 < 2);
      @(negedge clk);
    end
    checkOutput("midrst_before_pulse", c_pulse, 4'b1000);
    rst = 1'b0;
    c_in = '0;
    #1;
    checkOutput("midrst_pulse", c_pulse, '0);
    checkOutput("midrst_busy", c_busy, '0);
    checkOutput("midrst_ovf", c_ovf, '0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("postrst%0d_pulse", i), c_pulse, '0);
      checkOutput($sformatf("postrst%0d_busy", i), c_busy, '0);
    end

    // Randomized traffic on the default instance against the queue model.
    for (int c = 0; c < NCH; c++) begin
      m_q[c] = 0; m_next[c] = 0; m_last[c] = -100; m_ovf[c] = 1'b0; hold[c] = 0;
    end
    lvl = '0;
    for (int e = 1; e <= 420; e++) begin
      logic [NCH-1:0] clrv;
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(2, 5);
        end
        hold[c]--;
      end
      if (e > 400) lvl = '0;
      clrv = ($urandom_range(0, 7) == 0) ? NCH'($urandom_range(0, 15)) : '0;
      applyStimulus(lvl, clrv);
      @(posedge clk);
      modelStep(e, a_in, a_clr);
      @(negedge clk);
      checkOutput($sformatf("rnd%0d_pulse", e), a_pulse, ep);
      checkOutput($sformatf("rnd%0d_busy", e), a_busy, eb);
      checkOutput($sformatf("rnd%0d_ovf", e), a_ovf, eo);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
